pb_debouncer_multi: RTL and testbench
=====================================

# pb_debouncer_multi

Parametrised multi-channel push-button conditioner for the board I/O layer. It synchronises N_CH raw mechanical inputs and debounces each one with its own counter. For each channel it produces a clean level, single-cycle press and release pulses, a long-press pulse and an optional auto-repeat pulse train. It sits between the board pins and the user-interface FSMs and is a drop-in replacement for per-button single-channel debouncers.

## Interface
- N_CH, 4, number of independent button channels (≥1)
- DELAY, 15, consecutive stable cycles required to accept a level change (≥2)
- LONG_DELAY, 1000, cycles of debounced hold before long_pulse (≥1)
- REPEAT_PERIOD, 200, cycles between repeat_pulse assertions after long press; 0 disables repeat

- clk  in  1  base clock
- rst  in  1  reset; synchronous, active-high
- pb  in  N_CH  raw asynchronous button inputs, active-high
- pressed_status  out  N_CH  debounced level per channel
- pressed_pulse  out  N_CH  one-cycle pulse on accepted press
- released_pulse  out  N_CH  one-cycle pulse on accepted release
- long_pulse  out  N_CH  one-cycle pulse when a hold reaches LONG_DELAY
- repeat_pulse  out  N_CH  auto-repeat pulses during a long hold

## Operation
- All channels are fully independent. There is no shared state, and simultaneous events on different channels do not interact.
- Synchroniser: each pb bit passes through two flops, sync_aux and then sync. Both flops reset to 0.
- Debounce counter, width $clog2(DELAY):
  - Cleared when sync == status.
  - Otherwise it increments.
  - On the edge where the counter == DELAY-1 and sync != status, status toggles and the counter clears.
  - Any return of sync to status before that edge clears the counter, so glitches shorter than DELAY cycles are rejected.
- The same accept rule applies to press and release. Release is debounced too.
- Pulses are registered and asserted in the same cycle status changes:
  - pressed_pulse on a 0→1 transition.
  - released_pulse on a 1→0 transition.
- Hold counter, width $clog2(LONG_DELAY+1):
  - Cleared while status=0 and on the press edge.
  - Increments each cycle while status=1 and saturates at LONG_DELAY; it never wraps.
  - long_pulse asserts for exactly one cycle, on the cycle the hold counter reaches LONG_DELAY. At most one long_pulse per press.
- Repeat counter, width $clog2(REPEAT_PERIOD+1), active only after long_pulse while status=1:
  - repeat_pulse asserts together with long_pulse.
  - It then asserts every REPEAT_PERIOD cycles until release.
  - If REPEAT_PERIOD=0, repeat_pulse is tied to 0.
- Release clears the hold and repeat counters on the edge status falls. No long_pulse or repeat_pulse fires in or after the release cycle.
- Reset, including mid-operation, forces all of the following to 0 on the next edge:
  - synchroniser flops, counters and status;
  - all pulse outputs.
  - No released_pulse is generated by reset.

## Timing
- Reset value of every output: 0.
- Press latency: pb sampled high at edge 0 → sync high after edge 1 → status and pressed_pulse high after edge DELAY+1. pb must stay stable from edge 0 through edge DELAY.
- Release latency is identical (DELAY+1 edges from the first edge sampling pb low).
- long_pulse: LONG_DELAY cycles after the pressed_pulse cycle.
- repeat_pulse n (n≥0): LONG_DELAY + n·REPEAT_PERIOD cycles after pressed_pulse.
- Every pulse output is exactly one cycle wide. pressed_pulse and released_pulse are never both high on one channel.
- Outputs are registered; there are no combinational paths from pb to any output.

## Test plan
- Test parameters: N_CH=4, DELAY=4, LONG_DELAY=20, REPEAT_PERIOD=5.
- Clean press on ch0 held 10 cycles, then released:
  - pressed_status[0] and pressed_pulse[0] rise 5 edges after the first high sample.
  - released_pulse[0] occurs 5 edges after the first low sample.
  - No long_pulse.
- Bounce on ch1 (pb high 3 cycles, low 1, high 3, low):
  - No status change and no pulses.
  - A 4-cycle stable high is then accepted.
- Long hold on ch2 for 40 cycles after press:
  - long_pulse[2] at +20.
  - repeat_pulse[2] at +20, +25, +30, +35.
  - Release cancels any further repeats; there is exactly one long_pulse.
- Simultaneous press on ch0 and ch3 with different hold lengths:
  - Both pressed_pulses occur in the same cycle.
  - Each channel's release and long timing is independent.
- rst asserted mid-hold on ch2 (after long_pulse):
  - All outputs are 0 on the next edge, with no released_pulse.
  - A subsequent press is debounced normally from scratch.
- REPEAT_PERIOD=0 build, 40-cycle hold: one long_pulse and repeat_pulse constantly 0.

Source files
------------

// File: rtl/pb_debouncer_multi_if.sv
// Button bundle between board pins and the multi-channel debouncer.
// The master drives the raw pins; the slave (debouncer) returns conditioned events.
interface pb_debouncer_multi_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] pressed_status;
    logic [N_CH-1:0] pressed_pulse;
    logic [N_CH-1:0] released_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output pb,
        input  pressed_status,
        input  pressed_pulse,
        input  released_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  pb,
        output pressed_status,
        output pressed_pulse,
        output released_pulse,
        output long_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/pb_debouncer_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, per-channel debounce, press/release,
// long-press and auto-repeat pulses. Channels share nothing but clk/rst.
module pb_debouncer_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned DELAY         = 15,
    parameter int unsigned LONG_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD = 200
) (
    input logic                     clk,
    input logic                     rst,
    pb_debouncer_multi_if.slave     btn_io
);
    localparam int unsigned CntW  = $clog2(DELAY);
    localparam int unsigned HoldW = $clog2(LONG_DELAY + 1);

    localparam logic [CntW-1:0]  CntLast  = CntW'(DELAY - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_DELAY);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_DELAY - 1);

    logic [N_CH-1:0] status_vec;
    logic [N_CH-1:0] press_vec;
    logic [N_CH-1:0] release_vec;
    logic [N_CH-1:0] long_vec;
    logic [N_CH-1:0] rpt_vec;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             sync_aux_q, sync_q;
        logic             status_q, status_d;
        logic [CntW-1:0]  cnt_q, cnt_d;
        logic [HoldW-1:0] hold_q, hold_d;
        logic             accept, rise, fall;
        logic             press_q, release_q;
        logic             long_q, long_d;

        always_comb begin
            accept   = (sync_q != status_q) && (cnt_q == CntLast);
            rise     = accept && !status_q;
            fall     = accept && status_q;
            status_d = status_q ^ accept;
            if ((sync_q == status_q) || accept) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Hold counter saturates so long_pulse fires once per press.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (!status_q || fall) begin
                hold_d = '0;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == HoldLast);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_aux_q <= 1'b0;
                sync_q     <= 1'b0;
                status_q   <= 1'b0;
                cnt_q      <= '0;
                hold_q     <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                sync_aux_q <= btn_io.pb[g];
                sync_q     <= sync_aux_q;
                status_q   <= status_d;
                cnt_q      <= cnt_d;
                hold_q     <= hold_d;
                press_q    <= rise;
                release_q  <= fall;
                long_q     <= long_d;
            end
        end

        assign status_vec[g]  = status_q;
        assign press_vec[g]   = press_q;
        assign release_vec[g] = release_q;
        assign long_vec[g]    = long_q;

        if (REPEAT_PERIOD > 0) begin : g_rpt
            localparam int unsigned RepW = $clog2(REPEAT_PERIOD + 1);
            localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_PERIOD - 1);

            logic [RepW-1:0] rep_q, rep_d;
            logic            rpt_q, rpt_d;

            // First repeat coincides with long_pulse, then one per period while held.
            always_comb begin
                rep_d = rep_q;
                rpt_d = 1'b0;
                if (!status_q || fall) begin
                    rep_d = '0;
                end else if (long_d) begin
                    rpt_d = 1'b1;
                    rep_d = '0;
                end else if (hold_q == HoldMax) begin
                    if (rep_q == RepLast) begin
                        rpt_d = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rep_q <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rep_q <= rep_d;
                    rpt_q <= rpt_d;
                end
            end

            assign rpt_vec[g] = rpt_q;
        end else begin : g_no_rpt
            assign rpt_vec[g] = 1'b0;
        end
    end

    assign btn_io.pressed_status = status_vec;
    assign btn_io.pressed_pulse  = press_vec;
    assign btn_io.released_pulse = release_vec;
    assign btn_io.long_pulse     = long_vec;
    assign btn_io.repeat_pulse   = rpt_vec;

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench for pb_debouncer_multi: a repeat-enabled build and a REPEAT_PERIOD=0 build
// share the same pb stimulus.
module tb_pb_debouncer_multi;
    localparam int unsigned NCh     = 4;
    localparam int unsigned Dly     = 4;
    localparam int unsigned LongDly = 20;
    localparam int unsigned RptPer  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pb_debouncer_multi_if #(.N_CH(NCh)) bus_a ();
    pb_debouncer_multi_if #(.N_CH(NCh)) bus_b ();
    assign bus_b.pb = bus_a.pb;

    pb_debouncer_multi #(
        .N_CH(NCh), .DELAY(Dly), .LONG_DELAY(LongDly), .REPEAT_PERIOD(RptPer)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_io(bus_a)
    );

    pb_debouncer_multi #(
        .N_CH(NCh), .DELAY(Dly), .LONG_DELAY(LongDly), .REPEAT_PERIOD(0)
    ) u_dut_norpt (
        .clk(clk), .rst(rst), .btn_io(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int b_long_cnt = 0;
    logic [3:0] e_st, e_pp, e_rp, e_lp, e_rpt;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("norpt_repeat", bus_b.repeat_pulse, 4'b0000);
        b_long_cnt += $countones(bus_b.long_pulse);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] pp,
                           input logic [3:0] rp, input logic [3:0] lp, input logic [3:0] rpt);
        chk({tag, "/status"},  bus_a.pressed_status, st);
        chk({tag, "/press"},   bus_a.pressed_pulse,  pp);
        chk({tag, "/release"}, bus_a.released_pulse, rp);
        chk({tag, "/long"},    bus_a.long_pulse,     lp);
        chk({tag, "/repeat"},  bus_a.repeat_pulse,   rpt);
    endtask

    task automatic quiet(input string tag, input int n, input logic [3:0] st);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_all(tag, st, 4'b0, 4'b0, 4'b0, 4'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.pb = 4'b0000;
        tick();
        tick();
        chk_all("reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        rst = 1'b0;
        quiet("idle", 3, 4'b0000);

        // Clean press on ch0: 10 high samples, pulse on the 6th edge after the first one.
        bus_a.pb = 4'b0001;
        quiet("c0_pre", 5, 4'b0000);
        tick();
        chk_all("c0_press", 4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0);
        quiet("c0_hold", 4, 4'b0001);
        bus_a.pb = 4'b0000;
        quiet("c0_rel_pre", 5, 4'b0001);
        tick();
        chk_all("c0_release", 4'b0000, 4'b0, 4'b0001, 4'b0, 4'b0);
        quiet("c0_after", 25, 4'b0000);

        // Bounce on ch1 is rejected.
        bus_a.pb = 4'b0010;
        quiet("c1_b1", 3, 4'b0000);
        bus_a.pb = 4'b0000;
        quiet("c1_b2", 1, 4'b0000);
        bus_a.pb = 4'b0010;
        quiet("c1_b3", 3, 4'b0000);
        bus_a.pb = 4'b0000;
        quiet("c1_b4", 8, 4'b0000);
        // Four stable high samples are enough.
        bus_a.pb = 4'b0010;
        quiet("c1_p1", 4, 4'b0000);
        bus_a.pb = 4'b0000;
        quiet("c1_p2", 1, 4'b0000);
        tick();
        chk_all("c1_press", 4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0);
        quiet("c1_hold", 3, 4'b0010);
        tick();
        chk_all("c1_release", 4'b0000, 4'b0, 4'b0010, 4'b0, 4'b0);
        quiet("c1_after", 4, 4'b0000);

        // Long hold on ch2 with auto-repeat; the no-repeat build must give one long_pulse.
        b_long_cnt = 0;
        bus_a.pb = 4'b0100;
        quiet("c2_pre", 5, 4'b0000);
        tick();
        chk_all("c2_press", 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0);
        for (int k = 1; k <= 45; k++) begin
            tick();
            e_st  = (k < 40) ? 4'b0100 : 4'b0000;
            e_rp  = (k == 40) ? 4'b0100 : 4'b0000;
            e_lp  = (k == 20) ? 4'b0100 : 4'b0000;
            e_rpt = (k == 20 || k == 25 || k == 30 || k == 35) ? 4'b0100 : 4'b0000;
            chk_all("c2_hold", e_st, 4'b0, e_rp, e_lp, e_rpt);
            if (k == 34) bus_a.pb = 4'b0000;
        end
        chk("norpt_long_count", 4'(b_long_cnt), 4'd1);

        // Simultaneous press on ch0 and ch3, independent release and long timing.
        bus_a.pb = 4'b1001;
        quiet("c03_pre", 5, 4'b0000);
        tick();
        chk_all("c03_press", 4'b1001, 4'b1001, 4'b0, 4'b0, 4'b0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            e_st  = {(k < 30) ? 1'b1 : 1'b0, 2'b00, (k < 8) ? 1'b1 : 1'b0};
            e_rp  = {(k == 30) ? 1'b1 : 1'b0, 2'b00, (k == 8) ? 1'b1 : 1'b0};
            e_lp  = (k == 20) ? 4'b1000 : 4'b0000;
            e_rpt = (k == 20 || k == 25) ? 4'b1000 : 4'b0000;
            chk_all("c03_hold", e_st, 4'b0, e_rp, e_lp, e_rpt);
            if (k == 2) bus_a.pb = 4'b1000;
            if (k == 24) bus_a.pb = 4'b0000;
        end

        // Reset in the middle of a long hold on ch2.
        bus_a.pb = 4'b0100;
        quiet("c2r_pre", 5, 4'b0000);
        tick();
        chk_all("c2r_press", 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0);
        for (int k = 1; k <= 22; k++) begin
            tick();
            e_lp  = (k == 20) ? 4'b0100 : 4'b0000;
            chk_all("c2r_hold", 4'b0100, 4'b0, 4'b0, e_lp, e_lp);
        end
        rst = 1'b1;
        tick();
        chk_all("mid_reset", 4'b0000, 4'b0, 4'b0, 4'b0, 4'b0);
        rst = 1'b0;
        quiet("c2r_repre", 5, 4'b0000);
        tick();
        chk_all("c2r_repress", 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0);
        bus_a.pb = 4'b0000;
        quiet("c2r_rel_pre", 5, 4'b0100);
        tick();
        chk_all("c2r_release", 4'b0000, 4'b0, 4'b0100, 4'b0, 4'b0);
        quiet("tail", 3, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
